// File: rtl/axis_sink.sv
// AXI-Stream sink with a cycle-based TREADY throttle, beat/packet counters and an XOR checksum.
// Define AXIS_SINK_CHECK_EN to build in the incrementing-pattern checker that drives error_count.
module axis_sink #(
    parameter int DATA_WIDTH = 256,
    parameter int CNT_WIDTH  = 32,
    parameter int READY_ON   = 1,
    parameter int READY_OFF  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] AXIS_TDATA,
    input  logic                  AXIS_TVALID,
    input  logic                  AXIS_TLAST,
    output logic                  AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] data,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  packet_count,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam int PH_MAX = (READY_ON > READY_OFF) ? READY_ON : READY_OFF;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(READY_ON - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'((READY_OFF > 0) ? READY_OFF - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [PH_W-1:0]       r_phase;
    logic [PH_W-1:0]       w_phaseNext;
    logic                  r_tready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_checksum;
    logic [CNT_WIDTH-1:0]  r_beatCount;
    logic [CNT_WIDTH-1:0]  r_packetCount;

    // TREADY is registered from the state, so it trails a state change by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_phase  <= '0;
            r_tready <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_phase  <= w_phaseNext;
            r_tready <= (r_state == ON);
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_phaseNext = r_phase;
        if (!enable) begin
            w_stateNext = IDLE;
            w_phaseNext = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_stateNext = ON;
                    w_phaseNext = '0;
                end
                ON: begin
                    if (r_phase == ON_LAST) begin
                        w_phaseNext = '0;
                        if (READY_OFF > 0) begin
                            w_stateNext = OFF;
                        end
                    end else begin
                        w_phaseNext = r_phase + 1'b1;
                    end
                end
                OFF: begin
                    if (r_phase == OFF_LAST) begin
                        w_stateNext = ON;
                        w_phaseNext = '0;
                    end else begin
                        w_phaseNext = r_phase + 1'b1;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_phaseNext = '0;
                end
            endcase
        end
    end

    assign w_accept = AXIS_TVALID & r_tready;

    // Clear beats a simultaneous accepted beat for the statistics, but data still captures it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data        <= '0;
            r_checksum    <= '0;
            r_beatCount   <= '0;
            r_packetCount <= '0;
        end else begin
            if (w_accept) begin
                r_data <= AXIS_TDATA;
            end
            if (clear) begin
                r_checksum    <= '0;
                r_beatCount   <= '0;
                r_packetCount <= '0;
            end else if (w_accept) begin
                r_checksum <= r_checksum ^ AXIS_TDATA;
                if (r_beatCount != '1) begin
                    r_beatCount <= r_beatCount + 1'b1;
                end
                if (AXIS_TLAST && (r_packetCount != '1)) begin
                    r_packetCount <= r_packetCount + 1'b1;
                end
            end
        end
    end

`ifdef AXIS_SINK_CHECK_EN
    logic [31:0]          r_expected;
    logic [CNT_WIDTH-1:0] r_errorCount;

    // A mismatch resyncs the expected sequence to the received value, so one glitch costs one error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_expected   <= '0;
            r_errorCount <= '0;
        end else if (clear) begin
            r_expected   <= '0;
            r_errorCount <= '0;
        end else if (w_accept) begin
            if (AXIS_TDATA[31:0] == r_expected) begin
                r_expected <= r_expected + 32'd1;
            end else begin
                r_expected <= AXIS_TDATA[31:0] + 32'd1;
                if (r_errorCount != '1) begin
                    r_errorCount <= r_errorCount + 1'b1;
                end
            end
        end
    end

    assign error_count = r_errorCount;
`else
    assign error_count = '0;
`endif

    assign AXIS_TREADY  = r_tready;
    assign data         = r_data;
    assign checksum     = r_checksum;
    assign beat_count   = r_beatCount;
    assign packet_count = r_packetCount;

endmodule

// File: tb/tb_axis_sink.sv
// Directed bench for axis_sink: three instances (default, throttled, 4-bit counters) share stimulus;
// each instance's enable selects which one is under test.
module tb_axis_sink;

`ifdef AXIS_SINK_CHECK_EN
    localparam int CheckOn = 1;
`else
    localparam int CheckOn = 0;
`endif

    logic         clk;
    logic         reset;
    logic [2:0]   en;
    logic         clear;
    logic         tvalid;
    logic         tlast;
    logic [255:0] tdata;

    logic         readyA;
    logic [255:0] dataA;
    logic [255:0] checksumA;
    logic [31:0]  beatA;
    logic [31:0]  pktA;
    logic [31:0]  errA;

    logic         readyB;
    logic [31:0]  dataB;
    logic [31:0]  checksumB;
    logic [31:0]  beatB;
    logic [31:0]  pktB;
    logic [31:0]  errB;

    logic         readyC;
    logic [31:0]  dataC;
    logic [31:0]  checksumC;
    logic [3:0]   beatC;
    logic [3:0]   pktC;
    logic [3:0]   errC;

    int           checks;
    int           failures;
    logic [31:0]  xorC;
    int           vals [6];

    axis_sink dutA (
        .clk(clk), .reset(reset), .enable(en[0]), .clear(clear),
        .AXIS_TDATA(tdata), .AXIS_TVALID(tvalid), .AXIS_TLAST(tlast), .AXIS_TREADY(readyA),
        .data(dataA), .beat_count(beatA), .packet_count(pktA), .error_count(errA),
        .checksum(checksumA)
    );

    axis_sink #(.DATA_WIDTH(32), .READY_ON(2), .READY_OFF(3)) dutB (
        .clk(clk), .reset(reset), .enable(en[1]), .clear(clear),
        .AXIS_TDATA(tdata[31:0]), .AXIS_TVALID(tvalid), .AXIS_TLAST(tlast), .AXIS_TREADY(readyB),
        .data(dataB), .beat_count(beatB), .packet_count(pktB), .error_count(errB),
        .checksum(checksumB)
    );

    axis_sink #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dutC (
        .clk(clk), .reset(reset), .enable(en[2]), .clear(clear),
        .AXIS_TDATA(tdata[31:0]), .AXIS_TVALID(tvalid), .AXIS_TLAST(tlast), .AXIS_TREADY(readyC),
        .data(dataC), .beat_count(beatC), .packet_count(pktC), .error_count(errC),
        .checksum(checksumC)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic rst, input logic [2:0] ens, input logic clr,
                                 input logic vld, input logic last, input logic [255:0] d);
        reset  = rst;
        en     = ens;
        clear  = clr;
        tvalid = vld;
        tlast  = last;
        tdata  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        clk      = 1'b0;
        checks   = 0;
        failures = 0;
        xorC     = '0;
        vals     = '{0, 1, 2, 9, 10, 11};

        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("rstReadyA", readyA, 0);
        checkOutput("rstDataA", dataA, 0);
        checkOutput("rstChecksumA", checksumA, 0);
        checkOutput("rstBeatA", beatA, 0);
        checkOutput("rstPktA", pktA, 0);
        checkOutput("rstErrA", errA, 0);

        // TREADY rises on the second edge after enable
        applyStimulus(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("startReadyA1", readyA, 0);
        applyStimulus(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("startReadyA2", readyA, 1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 3'b001, 1'b0, 1'b1, (i == 7), 256'(i));
            checkOutput("streamReadyA", readyA, 1);
            checkOutput("streamBeatA", beatA, 256'(i + 1));
        end
        checkOutput("pktA", pktA, 1);
        checkOutput("dataA", dataA, 7);
        checkOutput("checksumA", checksumA, 0);
        checkOutput("errA", errA, 0);

        applyStimulus(1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 256'd5);
        checkOutput("clrBeatA", beatA, 0);
        checkOutput("clrChecksumA", checksumA, 0);
        checkOutput("clrDataA", dataA, 5);
        checkOutput("clrPktA", pktA, 0);
        applyStimulus(1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 256'd0);
        applyStimulus(1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 256'd1);
        checkOutput("postClrBeatA", beatA, 2);
        checkOutput("postClrChecksumA", checksumA, 1);
        checkOutput("postClrDataA", dataA, 1);
        checkOutput("postClrErrA", errA, 0);

        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("dropReadyA1", readyA, 1);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("dropReadyA2", readyA, 0);
        applyStimulus(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("reenReadyA1", readyA, 0);
        applyStimulus(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("reenReadyA2", readyA, 1);

        // Throttled instance: TREADY pattern 1,1,0,0,0 with TVALID held high
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 256'd7);
        checkOutput("throttleReadyB0", readyB, 0);
        for (int j = 0; j < 50; j++) begin
            applyStimulus(1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 256'(j + 100));
            checkOutput("throttleReadyB", readyB, ((j % 5) < 2) ? 1 : 0);
        end
        checkOutput("throttleBeatB", beatB, 20);

        // Saturation with 4-bit counters
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("satReadyC", readyC, 1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 3'b100, 1'b0, 1'b1, 1'b1, 256'(i));
            xorC = xorC ^ 32'(i);
        end
        checkOutput("satBeatC", beatC, 15);
        checkOutput("satPktC", pktC, 15);
        checkOutput("satDataC", dataC, 19);
        checkOutput("satChecksumC", checksumC, xorC);
        checkOutput("satErrC", errC, 0);

        // Reset in the middle of a packet, with TVALID and TREADY both high
        applyStimulus(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("midReadyC", readyC, 1);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 256'(i));
        end
        checkOutput("midBeatC", beatC, 3);
        applyStimulus(1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 256'd4);
        checkOutput("midRstReadyC", readyC, 0);
        checkOutput("midRstDataC", dataC, 0);
        checkOutput("midRstChecksumC", checksumC, 0);
        checkOutput("midRstBeatC", beatC, 0);
        checkOutput("midRstPktC", pktC, 0);
        checkOutput("midRstErrC", errC, 0);
        applyStimulus(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("midRecoverReadyC1", readyC, 0);
        applyStimulus(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("midRecoverReadyC2", readyC, 1);

        // Pattern stream with one discontinuity at 9
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 3'b100, 1'b0, 1'b1, (i == 5), 256'(vals[i]));
            if (i == 3) begin
                checkOutput("patErrAt9C", errC, 4'(CheckOn));
            end
        end
        checkOutput("patErrC", errC, 4'(CheckOn));
        checkOutput("patBeatC", beatC, 6);
        checkOutput("patPktC", pktC, 1);
        checkOutput("patDataC", dataC, 11);
        checkOutput("patChecksumC", checksumC, 11);

        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
